// File: rtl/vx_csr_access_ctrl.sv
// CSR access controller: serialised read-modify-write of core CSR storage for
// CSRRW/CSRRS/CSRRC instructions. The old CSR value is returned to writeback.
module vx_csr_access_ctrl #(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned UUID_WIDTH  = 44,
    parameter int unsigned ADDR_BITS   = 12,
    localparam int unsigned WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [UUID_WIDTH-1:0]         req_uuid,
    input  logic [WID_W-1:0]              req_wid,
    input  logic [NUM_THREADS-1:0]        req_tmask,
    input  logic [1:0]                    req_op,
    input  logic                          req_use_imm,
    input  logic [4:0]                    req_imm,
    input  logic [NUM_THREADS*XLEN-1:0]   req_rs1_data,
    input  logic [ADDR_BITS-1:0]          req_addr,

    output logic                          read_enable,
    output logic [UUID_WIDTH-1:0]         read_uuid,
    output logic [WID_W-1:0]              read_wid,
    output logic [ADDR_BITS-1:0]          read_addr,
    input  logic [XLEN-1:0]               read_data_ro,
    input  logic [XLEN-1:0]               read_data_rw,

    output logic                          write_enable,
    output logic [UUID_WIDTH-1:0]         write_uuid,
    output logic [WID_W-1:0]              write_wid,
    output logic [ADDR_BITS-1:0]          write_addr,
    output logic [XLEN-1:0]               write_data,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [UUID_WIDTH-1:0]         rsp_uuid,
    output logic [WID_W-1:0]              rsp_wid,
    output logic [NUM_THREADS-1:0]        rsp_tmask,
    output logic [NUM_THREADS*XLEN-1:0]   rsp_data,
    output logic                          rsp_illegal
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                  state;
    logic                    ready_q;
    logic [UUID_WIDTH-1:0]   uuid_q;
    logic [WID_W-1:0]        wid_q;
    logic [NUM_THREADS-1:0]  tmask_q;
    logic [1:0]              op_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [XLEN-1:0]         operand_q;
    logic [XLEN-1:0]         old_q;
    logic [XLEN-1:0]         new_q;
    logic                    read_en_q;
    logic                    write_en_q;
    logic                    rsp_valid_q;
    logic                    illegal_q;

    logic [XLEN-1:0]         sel_operand;
    logic                    lane_found;
    logic [XLEN-1:0]         old_val;
    logic [XLEN-1:0]         new_val;
    logic                    wr_due;
    logic                    ro_csr;

    // Source operand: zimm, else rs1 of the lowest active lane (0 if none active).
    always_comb begin
        sel_operand = '0;
        lane_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (req_tmask[i] && !lane_found) begin
                sel_operand = req_rs1_data[i*XLEN +: XLEN];
                lane_found  = 1'b1;
            end
        end
        if (req_use_imm) begin
            sel_operand = XLEN'(req_imm);
        end
    end

    // Modify step; the storage zeroes whichever bank is not addressed.
    always_comb begin
        old_val = read_data_ro | read_data_rw;
        case (op_q)
            2'b10:   new_val = old_val | operand_q;
            2'b11:   new_val = old_val & ~operand_q;
            default: new_val = operand_q;
        endcase
        ro_csr = (addr_q[ADDR_BITS-1 -: 2] == 2'b11);
        wr_due = (op_q != 2'b00) && !(op_q[1] && (operand_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            uuid_q      <= '0;
            wid_q       <= '0;
            tmask_q     <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            operand_q   <= '0;
            old_q       <= '0;
            new_q       <= '0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        uuid_q    <= req_uuid;
                        wid_q     <= req_wid;
                        tmask_q   <= req_tmask;
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        operand_q <= sel_operand;
                        ready_q   <= 1'b0;
                        read_en_q <= 1'b1;
                        state     <= READ;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                READ: begin
                    read_en_q  <= 1'b0;
                    old_q      <= old_val;
                    new_q      <= new_val;
                    write_en_q <= wr_due && !ro_csr;
                    illegal_q  <= wr_due && ro_csr;
                    state      <= WRITE;
                end
                WRITE: begin
                    write_en_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        illegal_q   <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = ready_q;

    assign read_enable  = read_en_q;
    assign read_uuid    = uuid_q;
    assign read_wid     = wid_q;
    assign read_addr    = addr_q;

    assign write_enable = write_en_q;
    assign write_uuid   = uuid_q;
    assign write_wid    = wid_q;
    assign write_addr   = addr_q;
    assign write_data   = new_q;

    assign rsp_valid    = rsp_valid_q;
    assign rsp_uuid     = uuid_q;
    assign rsp_wid      = wid_q;
    assign rsp_tmask    = tmask_q;
    assign rsp_data     = {NUM_THREADS{old_q}};
    assign rsp_illegal  = illegal_q;

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
// Bench for vx_csr_access_ctrl: directed scenarios plus randomized CSR traffic
// against a simple array-based CSR model.
module tb_vx_csr_access_ctrl;

    localparam int unsigned NT   = 4;
    localparam int unsigned XL   = 32;
    localparam int unsigned UW   = 44;
    localparam int unsigned AW   = 12;
    localparam int unsigned WW   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [UW-1:0]   req_uuid;
    logic [WW-1:0]   req_wid;
    logic [NT-1:0]   req_tmask;
    logic [1:0]      req_op;
    logic            req_use_imm;
    logic [4:0]      req_imm;
    logic [NT*XL-1:0] req_rs1_data;
    logic [AW-1:0]   req_addr;
    logic            read_enable;
    logic [UW-1:0]   read_uuid;
    logic [WW-1:0]   read_wid;
    logic [AW-1:0]   read_addr;
    logic [XL-1:0]   read_data_ro;
    logic [XL-1:0]   read_data_rw;
    logic            write_enable;
    logic [UW-1:0]   write_uuid;
    logic [WW-1:0]   write_wid;
    logic [AW-1:0]   write_addr;
    logic [XL-1:0]   write_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [UW-1:0]   rsp_uuid;
    logic [WW-1:0]   rsp_wid;
    logic [NT-1:0]   rsp_tmask;
    logic [NT*XL-1:0] rsp_data;
    logic            rsp_illegal;

    vx_csr_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
        .req_wid(req_wid), .req_tmask(req_tmask), .req_op(req_op),
        .req_use_imm(req_use_imm), .req_imm(req_imm),
        .req_rs1_data(req_rs1_data), .req_addr(req_addr),
        .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid),
        .read_addr(read_addr), .read_data_ro(read_data_ro), .read_data_rw(read_data_rw),
        .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
        .write_addr(write_addr), .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
        .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // CSR storage seen by the DUT; reference model keeps its own copy.
    logic [XL-1:0] mem [0:4095];
    logic [XL-1:0] model_mem [0:4095];
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [XL-1:0] preload_data;

    always @(posedge clk) begin
        if (preload_en) mem[preload_addr] <= preload_data;
        else if (write_enable) mem[write_addr] <= write_data;
    end

    assign read_data_ro = (read_addr[11:10] == 2'b11) ? mem[read_addr] : '0;
    assign read_data_rw = (read_addr[11:10] != 2'b11) ? mem[read_addr] : '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [XL-1:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        model_mem[a] = d;
        @(negedge clk);
        preload_en   = 1'b0;
    endtask

    // Issue one instruction (called at a negedge) and check every phase against the model.
    task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic use_imm, input logic [4:0] imm,
                           input logic [NT-1:0] tmask, input logic [NT*XL-1:0] rs1,
                           input logic [WW-1:0] wid, input int stall);
        logic [UW-1:0] uuid;
        logic [XL-1:0] operand, old_v, new_v;
        logic          due, ro, we, ill;
        int            w;

        uuid    = UW'({$urandom(), $urandom()});
        operand = '0;
        if (use_imm) operand = XL'(imm);
        else begin
            for (int i = 0; i < NT; i++) begin
                if (tmask[i]) begin
                    operand = rs1[i*XL +: XL];
                    break;
                end
            end
        end
        old_v = model_mem[addr];
        ro    = (addr >= 12'hC00);
        due   = (op != 2'd0) && !((op >= 2'd2) && (operand == 0));
        we    = due && !ro;
        ill   = due && ro;
        case (op)
            2'd2:    new_v = old_v | operand;
            2'd3:    new_v = old_v & ~operand;
            default: new_v = operand;
        endcase
        if (we) model_mem[addr] = new_v;

        req_uuid = uuid; req_wid = wid; req_tmask = tmask; req_op = op;
        req_use_imm = use_imm; req_imm = imm; req_rs1_data = rs1; req_addr = addr;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = AW'($urandom()); req_op = 2'($urandom()); req_uuid = '0;
        req_rs1_data = {$urandom(), $urandom(), $urandom(), $urandom()};

        check("read_en", read_enable, 1);
        check("read_wr_excl", write_enable, 0);
        check("read_addr", read_addr, addr);
        check("read_wid", read_wid, wid);
        check("read_uuid", read_uuid, uuid);
        check("busy_ready", req_ready, 0);
        @(negedge clk);
        check("write_en", write_enable, we);
        check("write_rd_excl", read_enable, 0);
        if (we) begin
            check("write_data", write_data, new_v);
            check("write_addr", write_addr, addr);
            check("write_uuid", write_uuid, uuid);
        end
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, {NT{old_v}});
        check("rsp_illegal", rsp_illegal, ill);
        check("rsp_uuid", rsp_uuid, uuid);
        check("rsp_wid", rsp_wid, wid);
        check("rsp_tmask", rsp_tmask, tmask);
        check("rsp_write_off", write_enable, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, {NT{old_v}});
            check("stall_uuid", rsp_uuid, uuid);
            check("stall_illegal", rsp_illegal, ill);
            check("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_rsp_ready", req_ready, 1);
        check("post_rsp_illegal", rsp_illegal, 0);
    endtask

    initial begin
        logic [AW-1:0] addrs [6];
        logic [NT*XL-1:0] lanes;

        addrs = '{12'h340, 12'h001, 12'hC00, 12'h300, 12'hC01, 12'h002};
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; preload_en = 1'b0;
        req_uuid = '0; req_wid = '0; req_tmask = '0; req_op = '0; req_use_imm = 1'b0;
        req_imm = '0; req_rs1_data = '0; req_addr = '0; preload_addr = '0; preload_data = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_read_en", read_enable, 0);
        check("rst_write_en", write_enable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_illegal", rsp_illegal, 0);
        check("rst_write_data", write_data, 0);

        preload(12'h340, 32'h0);
        preload(12'h001, 32'h2);
        preload(12'hC00, 32'h1234_5678);
        preload(12'h300, 32'hA5A5_0000);
        preload(12'hC01, 32'h0BAD_F00D);
        preload(12'h002, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        // Write then read back through a non-writing CSRRS.
        run_req(2'b01, 12'h340, 1'b0, 5'd0, 4'b0001, {96'h0, 32'hDEAD_BEEF}, 2'd1, 0);
        run_req(2'b10, 12'h340, 1'b0, 5'd0, 4'b0001, 128'h0, 2'd1, 0);
        // Set and clear with immediates.
        run_req(2'b10, 12'h001, 1'b1, 5'h05, 4'b1111, 128'h0, 2'd0, 0);
        run_req(2'b11, 12'h001, 1'b1, 5'h03, 4'b1111, 128'h0, 2'd2, 0);
        // Read-only protection.
        run_req(2'b01, 12'hC00, 1'b1, 5'h01, 4'b0001, 128'h0, 2'd3, 0);
        run_req(2'b10, 12'hC00, 1'b1, 5'h00, 4'b0001, 128'h0, 2'd3, 0);
        // Operand lane select.
        lanes = {32'h44, 32'h33, 32'h22, 32'h11};
        run_req(2'b01, 12'h300, 1'b0, 5'd0, 4'b1100, lanes, 2'd0, 0);
        run_req(2'b01, 12'h300, 1'b0, 5'd0, 4'b0000, lanes, 2'd0, 0);
        // Backpressure, then a request already waiting when IDLE returns.
        run_req(2'b00, 12'h001, 1'b0, 5'd0, 4'b0010, lanes, 2'd1, 5);
        run_req(2'b10, 12'h002, 1'b1, 5'h1F, 4'b0010, lanes, 2'd1, 0);

        // Reset while the instruction is in READ: nothing must come out.
        req_op = 2'b01; req_addr = 12'h340; req_use_imm = 1'b1; req_imm = 5'h15;
        req_tmask = 4'b0001; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("midop_read_en", read_enable, 1);
        reset = 1'b0;
        @(negedge clk);
        check("midop_rst_ready", req_ready, 0);
        check("midop_rst_write", write_enable, 0);
        check("midop_rst_rsp", rsp_valid, 0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midop_no_write", write_enable, 0);
            check("midop_no_rsp", rsp_valid, 0);
        end
        run_req(2'b10, 12'h340, 1'b1, 5'h00, 4'b0001, 128'h0, 2'd2, 0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            run_req(2'($urandom()), addrs[$urandom_range(0, 5)], 1'($urandom()),
                    5'($urandom()), 4'($urandom()),
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    2'($urandom()), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
